// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key conditioner: FSM state
// encodings and default timing constants for the 12 MHz board.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD         = 3'd2,
        ST_LONG         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } key_fsm_e;

    localparam int DEF_N_KEYS        = 4;
    localparam int DEF_DB_CYCLES     = 240000;    // 20 ms at 12 MHz
    localparam int DEF_LONG_CYCLES   = 12000000;  // 1 s at 12 MHz
    localparam int DEF_REPEAT_CYCLES = 2400000;   // 200 ms at 12 MHz

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce/long-press FSM with its
// counters, and registered one-cycle press/release/long/repeat pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W  = $clog2(max_int(DB_CYCLES, LONG_CYCLES) + 1);
    localparam int RCNT_W = $clog2(REPEAT_CYCLES);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYCLES - 1);

    // Raw level of a key that is not pressed
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    logic              sync1;
    logic              sync2;
    logic              ks;
    key_fsm_e          state;
    logic [CNT_W-1:0]  cnt;
    logic [RCNT_W-1:0] rcnt;

    // Two-stage synchroniser, parked at the released level during reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Normalised level: 1 means pressed whatever the board polarity
    assign ks = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // Debounce / hold FSM with registered level and pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ks) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!ks) begin
                        state <= ST_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state       <= ST_HELD;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        key_state   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!ks) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= ST_LONG;
                        long_pulse <= 1'b1;
                        rcnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    if (!ks) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt == REP_LAST) begin
                            rcnt         <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            rcnt <= rcnt + RCNT_W'(1);
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (ks) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        key_state     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    key_state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: N_KEYS independent copies of the
// single-channel debouncer sharing one clock and reset.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS        = DEF_N_KEYS,
    parameter int ACTIVE_LOW    = 1,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .key_raw      (key_in[i]),
            .key_state    (key_state[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: two instances (repeat on/off)
// driven by the same keys, compared every cycle against a run-length model.
module tb_key_debounce_multi;

    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int LG  = 32;
    localparam int REP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key_in = '1;

    logic [NK-1:0] ks_a, pp_a, rp_a, lp_a, rep_a;
    logic [NK-1:0] ks_b, pp_b, rp_b, lp_b, rep_b;

    key_debounce_multi #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DB_CYCLES(DB), .LONG_CYCLES(LG),
        .REPEAT_EN(1), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks_a),
        .press_pulse(pp_a), .release_pulse(rp_a), .long_pulse(lp_a),
        .repeat_pulse(rep_a)
    );

    key_debounce_multi #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DB_CYCLES(DB), .LONG_CYCLES(LG),
        .REPEAT_EN(0), .REPEAT_CYCLES(REP)
    ) dut_norep (
        .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks_b),
        .press_pulse(pp_b), .release_pulse(rp_b), .long_pulse(lp_b),
        .repeat_pulse(rep_b)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model, index 0 = repeat enabled, 1 = repeat disabled
    logic [1:0]    hist [2][NK];
    logic          lvl  [2][NK];
    int            run  [2][NK];
    int            hold [2][NK];
    logic [NK-1:0] e_ks [2];
    logic [NK-1:0] e_pr [2];
    logic [NK-1:0] e_rl [2];
    logic [NK-1:0] e_lg [2];
    logic [NK-1:0] e_rp [2];

    // Tallies of pulses seen on the outputs
    int press_cnt [NK];
    int rel_cnt   [NK];
    int long_cnt  [NK];
    int rep_cnt   [NK];
    int last_press[NK];
    int last_rel  [NK];
    int last_long [NK];
    int last_rep  [NK];
    int long_cnt_b;
    int rep_cnt_b;

    int            remaining[NK];
    logic [NK-1:0] rk;
    int            e0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NK; c++) begin
                hist[m][c] = 2'b00;
                lvl[m][c]  = 1'b0;
                run[m][c]  = 0;
                hold[m][c] = -1;
            end
            e_ks[m] = '0; e_pr[m] = '0; e_rl[m] = '0; e_lg[m] = '0; e_rp[m] = '0;
        end
    endtask

    // A level flips once it has been contradicted for DB+1 consecutive
    // synchronised samples; hold time counts samples since the last anchor.
    task automatic model_edge(input logic [NK-1:0] keys);
        logic ksv;
        for (int m = 0; m < 2; m++) begin
            e_pr[m] = '0; e_rl[m] = '0; e_lg[m] = '0; e_rp[m] = '0;
            for (int c = 0; c < NK; c++) begin
                ksv = hist[m][c][1];
                hist[m][c] = {hist[m][c][0], ~keys[c]};
                if (ksv != lvl[m][c]) run[m][c]++;
                else run[m][c] = 0;
                if (!lvl[m][c]) begin
                    if (run[m][c] == DB + 1) begin
                        lvl[m][c] = 1'b1; run[m][c] = 0; hold[m][c] = 0; e_pr[m][c] = 1'b1;
                    end
                end else if (!ksv) begin
                    hold[m][c] = -1;
                    if (run[m][c] == DB + 1) begin
                        lvl[m][c] = 1'b0; run[m][c] = 0; e_rl[m][c] = 1'b1;
                    end
                end else begin
                    if (hold[m][c] < 0) hold[m][c] = 0;
                    else hold[m][c]++;
                    if (hold[m][c] == LG) e_lg[m][c] = 1'b1;
                    else if (m == 0 && hold[m][c] > LG && ((hold[m][c] - LG) % REP) == 0)
                        e_rp[m][c] = 1'b1;
                end
                e_ks[m][c] = lvl[m][c];
            end
        end
    endtask

    task automatic clear_tallies();
        for (int c = 0; c < NK; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0; rep_cnt[c] = 0;
            last_press[c] = -1; last_rel[c] = -1; last_long[c] = -1; last_rep[c] = -1;
        end
        long_cnt_b = 0;
        rep_cnt_b  = 0;
    endtask

    task automatic check_output();
        check_vec("key_state",        32'(ks_a),  32'(e_ks[0]));
        check_vec("press_pulse",      32'(pp_a),  32'(e_pr[0]));
        check_vec("release_pulse",    32'(rp_a),  32'(e_rl[0]));
        check_vec("long_pulse",       32'(lp_a),  32'(e_lg[0]));
        check_vec("repeat_pulse",     32'(rep_a), 32'(e_rp[0]));
        check_vec("norep_key_state",  32'(ks_b),  32'(e_ks[1]));
        check_vec("norep_press",      32'(pp_b),  32'(e_pr[1]));
        check_vec("norep_release",    32'(rp_b),  32'(e_rl[1]));
        check_vec("norep_long",       32'(lp_b),  32'(e_lg[1]));
        check_vec("norep_repeat",     32'(rep_b), 32'(e_rp[1]));
        for (int c = 0; c < NK; c++) begin
            if (pp_a[c])  begin press_cnt[c]++; last_press[c] = cyc; end
            if (rp_a[c])  begin rel_cnt[c]++;   last_rel[c]   = cyc; end
            if (lp_a[c])  begin long_cnt[c]++;  last_long[c]  = cyc; end
            if (rep_a[c]) begin rep_cnt[c]++;   last_rep[c]   = cyc; end
            if (lp_b[c])  long_cnt_b++;
            if (rep_b[c]) rep_cnt_b++;
        end
    endtask

    // Drive keys and reset level between edges, then check after the edge
    task automatic apply_stimulus(input logic [NK-1:0] keys, input logic rst_val);
        @(negedge clk);
        key_in = keys;
        rst    = rst_val;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) model_reset();
        else model_edge(keys);
        check_output();
    endtask

    initial begin
        model_reset();
        clear_tallies();

        // Reset state
        repeat (3) apply_stimulus(4'hF, 1'b0);
        repeat (12) apply_stimulus(4'hF, 1'b1);

        // Clean press and release on channel 0
        clear_tallies();
        e0 = cyc + 1;
        repeat (20) apply_stimulus(4'b1110, 1'b1);
        check_vec("clean_press_count", 32'(press_cnt[0]), 32'd1);
        check_vec("clean_press_latency", 32'(last_press[0] - e0), 32'(DB + 2));
        check_vec("clean_others_idle", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
        e0 = cyc + 1;
        repeat (14) apply_stimulus(4'hF, 1'b1);
        check_vec("clean_release_count", 32'(rel_cnt[0]), 32'd1);
        check_vec("clean_release_latency", 32'(last_rel[0] - e0), 32'(DB + 2));

        // Bouncing key on channel 1
        clear_tallies();
        for (int i = 0; i < 40; i++)
            apply_stimulus((((i / 3) % 2) == 0) ? 4'b1101 : 4'b1111, 1'b1);
        e0 = cyc + 1;
        repeat (15) apply_stimulus(4'b1101, 1'b1);
        check_vec("bounce_press_count", 32'(press_cnt[1]), 32'd1);
        check_vec("bounce_press_latency", 32'(last_press[1] - e0), 32'(DB + 2));
        check_vec("bounce_no_release", 32'(rel_cnt[1]), 32'd0);
        repeat (14) apply_stimulus(4'hF, 1'b1);

        // Long press with auto-repeat on channel 2
        clear_tallies();
        repeat (100) apply_stimulus(4'b1011, 1'b1);
        e0 = cyc + 1;
        repeat (14) apply_stimulus(4'hF, 1'b1);
        check_vec("long_count", 32'(long_cnt[2]), 32'd1);
        check_vec("long_after_press", 32'(last_long[2] - last_press[2]), 32'(LG));
        check_vec("repeat_count", 32'(rep_cnt[2]), 32'd7);
        check_vec("last_repeat_offset", 32'(last_rep[2] - last_long[2]), 32'(7 * REP));
        check_vec("norep_long_count", 32'(long_cnt_b), 32'd1);
        check_vec("norep_repeat_count", 32'(rep_cnt_b), 32'd0);
        check_vec("long_release_latency", 32'(last_rel[2] - e0), 32'(DB + 2));

        // All four channels pressed on the same edge
        clear_tallies();
        e0 = cyc + 1;
        repeat (15) apply_stimulus(4'h0, 1'b1);
        for (int c = 0; c < NK; c++) begin
            check_vec($sformatf("simul_press_cycle_%0d", c), 32'(last_press[c] - e0), 32'(DB + 2));
            check_vec($sformatf("simul_press_count_%0d", c), 32'(press_cnt[c]), 32'd1);
        end
        repeat (14) apply_stimulus(4'hF, 1'b1);

        // Random key activity with random hold lengths per channel
        for (int c = 0; c < NK; c++) remaining[c] = 0;
        rk = '1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NK; c++) begin
                if (remaining[c] == 0) begin
                    rk[c] = 1'($urandom_range(0, 1));
                    remaining[c] = $urandom_range(1, 45);
                end
                remaining[c]--;
            end
            apply_stimulus(rk, 1'b1);
        end

        // Reset asserted while channel 3 is in release-wait, key held at release
        repeat (20) apply_stimulus(4'hF, 1'b1);
        repeat (20) apply_stimulus(4'b0111, 1'b1);
        repeat (4) apply_stimulus(4'hF, 1'b1);
        check_vec("pre_reset_key_state", 32'(ks_a), 32'h8);
        @(negedge clk);
        key_in = 4'b0111;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_output();
        check_vec("async_reset_outputs", 32'(ks_a | pp_a | rp_a | lp_a | rep_a), 32'd0);
        repeat (3) apply_stimulus(4'b0111, 1'b0);
        clear_tallies();
        e0 = cyc + 1;
        repeat (15) apply_stimulus(4'b0111, 1'b1);
        check_vec("post_reset_press_count", 32'(press_cnt[3]), 32'd1);
        check_vec("post_reset_press_latency", 32'(last_press[3] - e0), 32'(DB + 2));
        repeat (14) apply_stimulus(4'hF, 1'b1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
